// File: rtl/uart_rx_fsmd_if.sv
// Host-side bundle of the UART receiver: received word plus status pulses.
// master: driven by uart_rx_fsmd; slave: consumed by host logic.
interface uart_rx_fsmd_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  frame_err;
  logic                  parity_err;
  logic                  busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input parity_err,
    input busy
  );
endinterface

// File: rtl/uart_rx_fsmd.sv
// UART receiver FSMD: oversampled start detect, mid-bit LSB-first sampling.
// Ports: clk, hard_rst (async), soft_rst (sync), baud_tick, rx, bus (master).
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_fsmd #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            hard_rst,
  input  logic            soft_rst,
  input  logic            baud_tick,
  input  logic            rx,
  uart_rx_fsmd_if.master  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, state_d;

  logic meta, sync, prev;

  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  ferr_q;

  logic tick_clr, tick_inc;
  logic bit_clr, bit_inc;
  logic shift_en;
  logic done_ok, done_ferr;

`ifdef UART_RX_PARITY_EN
  logic par_en, done_perr;
  logic par_q, perr_q;
`endif

  // prev only advances on ticks so an edge between ticks is still
  // seen as prev=1, sync=0 at the next tick.
  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else if (soft_rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      sync <= meta;
      if (baud_tick) prev <= sync;
    end
  end

  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst)      state <= IDLE;
    else if (soft_rst) state <= IDLE;
    else               state <= state_d;
  end

  always_comb begin
    state_d   = state;
    tick_clr  = 1'b0;
    tick_inc  = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    shift_en  = 1'b0;
    done_ok   = 1'b0;
    done_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
    done_perr = 1'b0;
`endif
    if (baud_tick) begin
      unique case (state)
        IDLE: begin
          if (prev && !sync) begin
            tick_clr = 1'b1;
            state_d  = START;
          end
        end
        START: begin
          if (tick_cnt == HALF) begin
            if (!sync) begin
              tick_clr = 1'b1;
              bit_clr  = 1'b1;
              state_d  = DATA;
            end else begin
              state_d  = IDLE;
            end
          end else begin
            tick_inc = 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == FULL) begin
            shift_en = 1'b1;
            tick_clr = 1'b1;
            bit_inc  = 1'b1;
            if (bit_cnt == LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_inc = 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt == FULL) begin
            par_en   = 1'b1;
            tick_clr = 1'b1;
            state_d  = STOP;
          end else begin
            tick_inc = 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_cnt == FULL) begin
            tick_clr = 1'b1;
            state_d  = IDLE;
            if (!sync) begin
              done_ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_q != ^shreg) begin
              done_perr = 1'b1;
`endif
            end else begin
              done_ok = 1'b1;
            end
          end else begin
            tick_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shifting in from the top lands bit 0 in the LSB after
  // DATA_WIDTH samples.
  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else if (soft_rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (tick_clr)      tick_cnt <= '0;
      else if (tick_inc) tick_cnt <= tick_cnt + 1'b1;
      if (bit_clr)       bit_cnt <= '0;
      else if (bit_inc)  bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) begin
        shreg <= {sync, shreg[DATA_WIDTH-1:1]};
      end
      if (done_ok) data_q <= shreg;
      valid_q <= done_ok;
      ferr_q  <= done_ferr;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge hard_rst) begin
    if (hard_rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else if (soft_rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (par_en) par_q <= sync;
      perr_q <= done_perr;
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fsmd.sv
// Scoreboard bench for uart_rx_fsmd: directed frames, glitch, break, abort.
// Honours UART_RX_PARITY_EN by adding a parity bit to every frame.
module tb_uart_rx_fsmd;

  localparam int DW  = 8;
  localparam int OS  = 16;
  localparam int DIV = 4;
  localparam int BIT = OS * DIV;

  logic clk = 1'b0;
  logic hard_rst = 1'b1;
  logic soft_rst = 1'b0;
  logic baud_tick = 1'b0;
  logic rx = 1'b1;

  uart_rx_fsmd_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_fsmd #(
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS)
  ) dut (
    .clk(clk),
    .hard_rst(hard_rst),
    .soft_rst(soft_rst),
    .baud_tick(baud_tick),
    .rx(rx),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      baud_tick = (c == DIV - 1);
      c = (c + 1) % DIV;
    end
  end

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic push(input int k, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h required=%h", n, a, e);
    end
  endtask

  // kind: 0 rx_valid, 1 frame_err, 2 parity_err
  logic pv = 1'b0;
  always @(negedge clk) begin : mon
    int   k;
    logic any;
    exp_t e;
    if (!hard_rst) begin
      any = bus.rx_valid | bus.frame_err | bus.parity_err;
      if (pv) begin
        total++;
        if (any) begin
          bad++;
          $display("FAIL pulse_width got=2+ clk required=1 clk");
        end
      end
      if (any) begin
        k = bus.rx_valid ? 0 : (bus.frame_err ? 1 : 2);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse kind=%0d data=%h required=none",
                   k, bus.rx_data);
        end else begin
          e = sb.pop_front();
          if (k != e.kind || bus.rx_data !== e.data) begin
            bad++;
            $display("FAIL pulse got kind=%0d data=%h required kind=%0d data=%h",
                     k, bus.rx_data, e.kind, e.data);
          end
        end
      end
      pv = any;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(s);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_par(input logic [7:0] d, input logic p);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(1'b1);
  endtask
`endif

  initial begin
    logic [7:0] ab;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", 32'(bus.rx_data), 32'h0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_parity_err", 32'(bus.parity_err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    hard_rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);

    push(0, 8'hA5);
    send_frame(8'hA5, 1'b1);
    chk("a5_busy_after", 32'(bus.busy), 32'h0);
    chk("a5_rx_data", 32'(bus.rx_data), 32'hA5);
    repeat (BIT) @(negedge clk);

    rx = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    chk("glitch_busy_start", 32'(bus.busy), 32'h1);
    repeat (10 * DIV) @(negedge clk);
    chk("glitch_busy_idle", 32'(bus.busy), 32'h0);
    repeat (BIT) @(negedge clk);

    push(0, 8'h11);
    send_frame(8'h11, 1'b1);
    push(1, 8'h11);
    send_frame(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("ferr_rx_data_kept", 32'(bus.rx_data), 32'h11);

    push(0, 8'h00);
    push(0, 8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (BIT) @(negedge clk);
    chk("b2b_rx_data", 32'(bus.rx_data), 32'hFF);

    ab = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(ab[i]);
    rx = ab[3];
    repeat (BIT / 2) @(negedge clk);
    soft_rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    chk("soft_rst_busy", 32'(bus.busy), 32'h0);
    chk("soft_rst_rx_data", 32'(bus.rx_data), 32'h0);
    repeat (2 * BIT) @(negedge clk);
    push(0, 8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (BIT) @(negedge clk);
    chk("after_abort_rx_data", 32'(bus.rx_data), 32'h5A);

`ifdef UART_RX_PARITY_EN
    push(2, 8'h5A);
    send_par(8'h07, 1'b0);
    repeat (BIT) @(negedge clk);
    chk("perr_rx_data_kept", 32'(bus.rx_data), 32'h5A);
    push(0, 8'h07);
    send_par(8'h07, 1'b1);
    repeat (BIT) @(negedge clk);
    chk("par_ok_rx_data", 32'(bus.rx_data), 32'h07);
`endif

    repeat (100) @(negedge clk);
    chk("missing_pulses", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
